// File: rtl/progressive_counter.sv
// Progressive counter: counts up (0 -> limit) or down (limit -> 0) at a
// prescaled rate, then either stops in DONE or reloads and keeps counting.
// All outputs are registered; reset is asynchronous and active-low.
module progressive_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PRESCALE    = 1,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             initSignal,
    input  logic             abort,
    input  logic             hold,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] suma,
    output logic             finalSignal,
    output logic             done_pulse,
    output logic             busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCount = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // Prescaler is sized for the largest legal PRESCALE (65535).
    localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] suma_q, suma_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             down_q, down_d;
    logic [15:0]      presc_q, presc_d;
    logic             final_q, final_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] start_val;

    // Target and reload value derive only from the latched operands.
    always_comb begin
        target    = down_q ? '0 : limit_q;
        start_val = down_q ? limit_q : '0;
    end

    // Next-state logic: abort dominates, then per-state behaviour.
    always_comb begin
        state_d = state_q;
        suma_d  = suma_q;
        limit_d = limit_q;
        down_d  = down_q;
        presc_d = presc_q;
        final_d = final_q;
        pulse_d = 1'b0;
        tick    = 1'b0;

        if (abort) begin
            state_d = StIdle;
            suma_d  = '0;
            presc_d = '0;
            final_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (initSignal) begin
                        state_d = StCount;
                        limit_d = limit;
                        down_d  = down;
                        suma_d  = down ? limit : '0;
                        presc_d = '0;
                        final_d = 1'b0;
                    end
                end
                StCount: begin
                    if (!hold) begin
                        tick    = (presc_q == PresLast);
                        presc_d = tick ? '0 : presc_q + 16'd1;
                        if (tick) begin
                            if (suma_q == target) begin
                                pulse_d = 1'b1;
                                if (AUTO_RELOAD) begin
                                    suma_d = start_val;
                                end else begin
                                    state_d = StDone;
                                    final_d = 1'b1;
                                end
                            end else if (down_q) begin
                                suma_d = suma_q - 1'b1;
                            end else begin
                                suma_d = suma_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    suma_d  = '0;
                    presc_d = '0;
                    final_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == StCount);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            suma_q  <= '0;
            limit_q <= '0;
            down_q  <= 1'b0;
            presc_q <= '0;
            final_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            suma_q  <= suma_d;
            limit_q <= limit_d;
            down_q  <= down_d;
            presc_q <= presc_d;
            final_q <= final_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign suma        = suma_q;
    assign finalSignal = final_q;
    assign done_pulse  = pulse_q;
    assign busy        = busy_q;

endmodule
